// File: rtl/alu4_bist_ctrl.sv
// BIST controller for the alu4 netlist: 14-bit LFSR pattern source and 8-bit MISR compactor.
// Define BIST_GOLDEN_CMP_EN to add the pass output and the GOLDEN signature comparator.
module alu4_bist_ctrl #(
  parameter int          N_PAT     = 1024,
  parameter logic [13:0] LFSR_SEED = 14'h0001,
  parameter logic [7:0]  MISR_SEED = 8'h00,
  parameter logic [7:0]  GOLDEN    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [13:0] pat,
  input  logic [7:0]  rsp,
  output logic        busy,
  output logic        done,
  output logic [7:0]  signature
`ifdef BIST_GOLDEN_CMP_EN
  ,
  output logic        pass
`endif
);

  localparam int CW = $clog2(N_PAT + 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [13:0]   SEED = (LFSR_SEED == 14'h0000) ? 14'h0001 : LFSR_SEED;
  localparam logic [CW-1:0] LAST = CW'(N_PAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          fb_p;
  logic          fb_m;

  assign fb_p = pat[13] ^ pat[12] ^ pat[11] ^ pat[1];
  assign fb_m = signature[7] ^ signature[5] ^ signature[4] ^ signature[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)            state_next = IDLE;
        else if (cnt == LAST) state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An abort cycle performs no update, so pat and signature freeze at their partial values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= 14'h0001;
      signature <= 8'h00;
      cnt       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (!abort) begin
            pat       <= SEED;
            signature <= MISR_SEED;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            pat       <= {pat[12:0], fb_p};
            signature <= {signature[6:0], fb_m} ^ rsp;
            cnt       <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIST_GOLDEN_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            pass <= 1'b0;
    else if ((state == LOAD) && !abort) pass <= 1'b0;
    else if (state == FINISH)           pass <= (signature == GOLDEN);
  end
`endif

endmodule
